sipo_load: RTL and testbench

Serial-in/parallel-out frame assembler feeding the PE array. Accepts one `DATA_WIDTH*2`-bit word per cycle over a valid/ready handshake and assembles `PE_NUM` words into one parallel frame. It presents the frame with a valid/ready handshake to the array input. It mirrors the output-side parallel-to-serial stage, so lane 0 holds the first word received.

---
 rtl/sipo_load_pkg.sv | 13 +
 rtl/sipo_ctrl.sv | 113 +++++++++++
 rtl/sipo_load.sv | 54 +++++
 tb/tb_sipo_load.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sipo_load_pkg.sv
// Shared constants and state encoding for the sipo_load frame assembler.
package sipo_load_pkg;

  localparam int PE_NUM_DEF = 8;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    FLUSH   = 2'd2
  } sipo_state_t;

endpackage

// File: rtl/sipo_ctrl.sv
// Control for sipo_load: FSM, word counter, handshakes and shift enable.
// Optional short-frame support is built when SIPO_TLAST_EN is defined.
module sipo_ctrl
  import sipo_load_pkg::*;
#(
  parameter int PE_NUM = PE_NUM_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic s_in_v,
`ifdef SIPO_TLAST_EN
  input  logic s_in_last,
  output logic p_out_short,
`endif
  input  logic p_out_rdy,
  output logic s_in_rdy,
  output logic p_out_v,
  output logic shift,
  output logic zero_in
);

  localparam int CW = $clog2(PE_NUM);
  localparam logic [CW-1:0] CNT_LAST = CW'(PE_NUM - 1);

  sipo_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          rdy_c;
  logic          acc;
  logic          last_w;

`ifdef SIPO_TLAST_EN
  assign last_w      = s_in_last;
  assign p_out_short = short_q;
`else
  assign last_w = 1'b0;
`endif

  // Ready is held low while reset is asserted regardless of state.
  assign s_in_rdy = rdy_c & rst;
  assign acc      = s_in_v & s_in_rdy;

  // State, counter and short-frame flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = short_q;
    rdy_c   = 1'b0;
    p_out_v = 1'b0;
    shift   = 1'b0;
    zero_in = 1'b0;
    case (state_q)
      COLLECT: begin
        rdy_c = 1'b1;
        if (acc) begin
          shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = FULL;
            cnt_d   = '0;
            short_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (last_w) state_d = FLUSH;
          end
        end
      end
      FULL: begin
        p_out_v = 1'b1;
        rdy_c   = p_out_rdy;
        if (p_out_rdy) begin
          short_d = 1'b0;
          state_d = COLLECT;
          cnt_d   = '0;
          if (acc) begin
            // Word arriving with the frame hand-off starts the next frame.
            shift = 1'b1;
            cnt_d = CW'(1);
            if (last_w) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        shift   = 1'b1;
        zero_in = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FULL;
          cnt_d   = '0;
          short_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/sipo_load.sv
// Serial-in/parallel-out frame assembler: PE_NUM words form one frame,
// lane 0 holds the first word received. SIPO_TLAST_EN adds short frames.
module sipo_load
  import sipo_load_pkg::*;
#(
  parameter int PE_NUM = PE_NUM_DEF,
  parameter int WW     = 2 * DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_in_v,
  input  logic [WW-1:0]        s_in,
  output logic                 s_in_rdy,
`ifdef SIPO_TLAST_EN
  input  logic                 s_in_last,
  output logic                 p_out_short,
`endif
  output logic [PE_NUM*WW-1:0] p_out,
  output logic                 p_out_v,
  input  logic                 p_out_rdy
);

  logic [PE_NUM-1:0][WW-1:0] sr;
  logic                      shift;
  logic                      zero_in;

  sipo_ctrl #(.PE_NUM(PE_NUM)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .s_in_v      (s_in_v),
`ifdef SIPO_TLAST_EN
    .s_in_last   (s_in_last),
    .p_out_short (p_out_short),
`endif
    .p_out_rdy   (p_out_rdy),
    .s_in_rdy    (s_in_rdy),
    .p_out_v     (p_out_v),
    .shift       (shift),
    .zero_in     (zero_in)
  );

  // Shift toward lane 0; the newest word (or pad zero) enters the top lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr <= '0;
    end else if (shift) begin
      for (int k = 0; k < PE_NUM - 1; k++) sr[k] <= sr[k+1];
      sr[PE_NUM-1] <= zero_in ? '0 : s_in;
    end
  end

  assign p_out = sr;

endmodule

// File: tb/tb_sipo_load.sv
// Self-checking bench for sipo_load (PE_NUM=4, WW=32) against a queue model.
module tb_sipo_load;

  localparam int PE = 4;
  localparam int W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_in_v;
  logic [W-1:0]    s_in;
  logic            s_in_rdy;
  logic [PE*W-1:0] p_out;
  logic            p_out_v;
  logic            p_out_rdy;
`ifdef SIPO_TLAST_EN
  logic            s_in_last;
  logic            p_out_short;
`endif

  sipo_load #(.PE_NUM(PE), .WW(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_in_v      (s_in_v),
    .s_in        (s_in),
    .s_in_rdy    (s_in_rdy),
`ifdef SIPO_TLAST_EN
    .s_in_last   (s_in_last),
    .p_out_short (p_out_short),
`endif
    .p_out       (p_out),
    .p_out_v     (p_out_v),
    .p_out_rdy   (p_out_rdy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: words received so far in the current frame, a completed frame
  // waiting for the consumer, and a pending zero-pad phase.
  logic [W-1:0]    q[$];
  logic [PE*W-1:0] frame_exp;
  bit              pending;
  bit              short_exp;
  bit              flushing;

  task automatic chk(input string tag, input logic [PE*W-1:0] obs, input logic [PE*W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pending   = 0;
    short_exp = 0;
    flushing  = 0;
  endtask

  task automatic close_frame(input bit is_short);
    frame_exp = '0;
    for (int i = 0; i < q.size(); i++) frame_exp[i*W +: W] = q[i];
    pending   = 1;
    short_exp = is_short;
    flushing  = 0;
    q.delete();
  endtask

  // One clock of stimulus: drive, check settled outputs, advance model.
  task automatic step(input logic v, input logic [W-1:0] w, input logic ordy, input logic last);
    bit rdy_e;
    s_in_v    = v;
    s_in      = w;
    p_out_rdy = ordy;
`ifdef SIPO_TLAST_EN
    s_in_last = last;
`endif
    #1;
    rdy_e = flushing ? 1'b0 : (pending ? ordy : 1'b1);
    chk("s_in_rdy", {127'd0, s_in_rdy}, {127'd0, rdy_e});
    chk("p_out_v", {127'd0, p_out_v}, {127'd0, pending});
    if (pending) chk("p_out", p_out, frame_exp);
`ifdef SIPO_TLAST_EN
    chk("p_out_short", {127'd0, p_out_short}, {127'd0, pending && short_exp});
`endif
    @(posedge clk);
    if (pending && ordy) pending = 0;
    if (flushing) begin
      q.push_back('0);
      if (q.size() == PE) close_frame(1);
    end else if (v && rdy_e) begin
      q.push_back(w);
      if (q.size() == PE) close_frame(0);
      else if (last) flushing = 1;
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_in_rdy", {127'd0, s_in_rdy}, '0);
    chk("rst_p_out_v", {127'd0, p_out_v}, '0);
    chk("rst_p_out", p_out, '0);
`ifdef SIPO_TLAST_EN
    chk("rst_p_out_short", {127'd0, p_out_short}, '0);
`endif
  endtask

  logic [PE*W-1:0] held;
  logic            lastr;

  initial begin
    rst = 1'b0; s_in_v = 0; s_in = '0; p_out_rdy = 0;
`ifdef SIPO_TLAST_EN
    s_in_last = 0;
`endif
    model_clear();
    repeat (2) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;

    // First frame, with a direct check of the lane ordering.
    step(1, 32'h11, 1, 0); step(1, 32'h22, 1, 0);
    step(1, 32'h33, 1, 0); step(1, 32'h44, 1, 0);
    chk("first_frame", p_out, {32'h44, 32'h33, 32'h22, 32'h11});
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);

    // Back-to-back frames, no input bubble.
    for (int i = 1; i <= 8; i++) step(1, W'(i), 1, 0);
    step(0, '0, 1, 0);

    // Backpressure: frame held for 5 cycles while upstream keeps offering.
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + W'(i), 0, 0);
    held = p_out;
    for (int i = 0; i < 5; i++) step(1, 32'hBEEF, 0, 0);
    chk("bp_stable", p_out, held);
    step(1, 32'hC0, 1, 0);
    for (int i = 1; i < 4; i++) step(1, 32'hC0 + W'(i), 1, 0);
    step(0, '0, 1, 0);

    // Toggling valid: only accepted words land in the frame.
    for (int i = 0; i < 8; i++) step(i[0] == 1'b0, 32'hD0 + W'(i), 1, 0);
    step(0, '0, 1, 0);

    // Reset mid-frame discards the partial frame.
    step(1, 32'hE1, 1, 0); step(1, 32'hE2, 1, 0);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_clear();
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 32'hF0 + W'(i), 1, 0);
    chk("post_reset_frame", p_out, {32'hF3, 32'hF2, 32'hF1, 32'hF0});
    step(0, '0, 1, 0);

`ifdef SIPO_TLAST_EN
    // Short frame: two words then two pad cycles.
    step(1, 32'hA, 1, 0); step(1, 32'hB, 1, 1);
    step(1, 32'h99, 0, 0); step(1, 32'h99, 0, 0);
    chk("short_frame", p_out, {32'h0, 32'h0, 32'hB, 32'hA});
    chk("short_flag", {127'd0, p_out_short}, 128'd1);
    step(0, '0, 1, 0);
    // last on the final word is an ordinary frame.
    for (int i = 0; i < 4; i++) step(1, 32'h50 + W'(i), 1, i == 3);
    step(0, '0, 1, 0);
`endif

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      lastr = 1'b0;
`ifdef SIPO_TLAST_EN
      lastr = ($urandom_range(0, 5) == 0);
`endif
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, lastr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
